uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, baudClock rising edges per serial bit; only value 16 supported.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port enable  input  1  address-decode select for this peripheral.
REQ-005 SHALL have port mem_valid  input  1  bus request valid.
REQ-006 SHALL have port mem_ready  output  1  bus acknowledge; 0 when enable=0.
REQ-007 SHALL have port mem_instr  input  1  unused.
REQ-008 SHALL have port mem_wstrb  input  4  write strobes; 0000 means read.
REQ-009 SHALL have port mem_wdata  input  32  unused; only the strobe matters.
REQ-010 SHALL have port mem_addr  input  32  unused; decode is external via enable.
REQ-011 SHALL have port mem_rdata  output  32  status/data word; 0 when enable=0 (wire-OR bus).
REQ-012 SHALL have port baudClock  input  1  free-running 16x bit-rate clock, sampled in the clk domain.
REQ-013 SHALL have port serialIn  input  1  asynchronous serial line; idle high.

Function
REQ-014 SHALL pass serialIn through a 2-flop synchronizer (reset value 1); rxd = synchronized value.
REQ-015 SHALL generate tick = 1-cycle pulse on each rising edge of baudClock (registered previous value, reset 0).
REQ-016 SHALL frame 8N1, LSB first; a second stop bit is not required.
REQ-017 SHALL implement states IDLE, START, DATA, STOP, BREAK; the 4-bit tickCount and 3-bit bitCount advance only on tick.
REQ-018 IDLE: on any clk cycle with rxd=0 -> START, tickCount=0.
REQ-019 START: on the tick where tickCount==7, rxd=0 -> DATA with tickCount=0, bitCount=0; rxd=1 -> IDLE (glitch rejected, no flags).
REQ-020 DATA: on the tick where tickCount==15, shift rxd into shifter[7], shift right, tickCount=0; the 8th sample (bitCount==7) -> STOP.
REQ-021 STOP: on the tick where tickCount==15, rxd=1 -> deliver byte, go to IDLE; rxd=0 -> set frameErr, discard byte, go to BREAK.
REQ-022 BREAK: remain until rxd=1, then -> IDLE; no start detection while in BREAK.
REQ-023 Delivery: when dataValid=0, or dataValid is cleared by a read in the same cycle, load rxData=shifter and set dataValid=1.
REQ-024 Delivery with dataValid=1 and no clearing read that cycle: discard the new byte, keep rxData, set overrun=1.
REQ-025 Bus: rdy is registered as mem_valid & enable each cycle, so mem_ready follows valid with 1-cycle latency.
REQ-026 mem_rdata = enable ? {21'b0, overrun, frameErr, dataValid, rxData[7:0]} : 0, combinational from registers.
REQ-027 A read (mem_wstrb==0) clears dataValid in the cycle mem_valid & enable & rdy; rxData is unchanged.
REQ-028 A write with mem_wstrb[1]=1 and mem_valid & enable clears frameErr and overrun; other writes have no effect.
REQ-029 If a flag set and a write clear fall in the same cycle, set wins.
REQ-030 Latency: dataValid rises 1 clk after the tick that samples the stop bit.

Reset
REQ-031 While reset=1: state=IDLE, tickCount=0, bitCount=0, shifter=0, rxData=0, dataValid=0, frameErr=0, overrun=0, rdy=0, synchronizer=11, tick history=0.
REQ-032 Reset asserted mid-frame SHALL abort reception; after release the receiver waits in IDLE for a fresh falling edge; any partial byte is lost.

Verification
REQ-033 Send 0xA5 8N1 at baudClock/16 -> after the stop bit, mem_rdata[10:0]=0x1A5; a read then gives dataValid=0.
REQ-034 Pulse serialIn low for 3 baudClock periods -> state returns to IDLE, dataValid=0, frameErr=0.
REQ-035 Send 0x3C with stop bit held low for 2 bit times -> frameErr=1, dataValid=0, no new start until the line goes high; a write with wstrb=0010 then clears frameErr.
REQ-036 Send 0x11 then 0x22 without reading -> rxData=0x11, dataValid=1, overrun=1.
REQ-037 Read issued in the same cycle as delivery of 0x55 -> rxData=0x55, dataValid=1, overrun=0.
REQ-038 Assert reset during data bit 4 of 0xFF, release, send 0x0F -> first received byte is 0x0F, no flags set.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling from an external baud clock, exposed
// as a single status/data word on a valid/ready memory bus.
module uart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic        mem_instr,
   input  logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_addr,
   output logic [31:0] mem_rdata,
   input  logic        baudClock,
   input  logic        serialIn
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

   logic [1:0] sync_q;
   logic       baud_q;
   logic       rxd;
   logic       tick;

   logic [2:0] state_q, state_d;
   logic [3:0] tick_cnt_q, tick_cnt_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shifter_q, shifter_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       data_valid_q, data_valid_d;
   logic       frame_err_q, frame_err_d;
   logic       overrun_q, overrun_d;
   logic       rdy_q;

   logic       deliver;
   logic       frame_fault;
   logic       rd_clr;
   logic       wr_clr;

   // Address, write data and instruction flag carry no information for this block.
   logic       unused_bus;
   assign unused_bus = ^{mem_instr, mem_wdata, mem_addr};

   assign rxd  = sync_q[1];
   assign tick = baudClock & ~baud_q;

   always_comb begin
      state_d     = state_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shifter_d   = shifter_q;
      deliver     = 1'b0;
      frame_fault = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (!rxd) begin
               state_d    = S_START;
               tick_cnt_d = 4'd0;
            end
         end
         S_START: begin
            // Re-check the line half a bit in so short glitches are rejected.
            if (tick) begin
               if (tick_cnt_q == TICK_MID) begin
                  tick_cnt_d = 4'd0;
                  bit_cnt_d  = 3'd0;
                  state_d    = rxd ? S_IDLE : S_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = 4'd0;
                  shifter_d  = {rxd, shifter_q[7:1]};
                  if (bit_cnt_q == 3'd7) begin
                     state_d = S_STOP;
                  end else begin
                     bit_cnt_d = bit_cnt_q + 3'd1;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               if (tick_cnt_q == TICK_LAST) begin
                  tick_cnt_d = 4'd0;
                  if (rxd) begin
                     deliver = 1'b1;
                     state_d = S_IDLE;
                  end else begin
                     frame_fault = 1'b1;
                     state_d     = S_BREAK;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + 4'd1;
               end
            end
         end
         S_BREAK: begin
            if (rxd) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign rd_clr = mem_valid & enable & rdy_q & (mem_wstrb == 4'b0000);
   assign wr_clr = mem_valid & enable & mem_wstrb[1];

   // Flag sets are applied last so they win over a simultaneous bus clear.
   always_comb begin
      rx_data_d    = rx_data_q;
      data_valid_d = data_valid_q;
      frame_err_d  = frame_err_q;
      overrun_d    = overrun_q;
      if (rd_clr) begin
         data_valid_d = 1'b0;
      end
      if (wr_clr) begin
         frame_err_d = 1'b0;
         overrun_d   = 1'b0;
      end
      if (frame_fault) begin
         frame_err_d = 1'b1;
      end
      if (deliver) begin
         if (!data_valid_q || rd_clr) begin
            rx_data_d    = shifter_q;
            data_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q       <= 2'b11;
         baud_q       <= 1'b0;
         state_q      <= S_IDLE;
         tick_cnt_q   <= 4'd0;
         bit_cnt_q    <= 3'd0;
         shifter_q    <= 8'd0;
         rx_data_q    <= 8'd0;
         data_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         overrun_q    <= 1'b0;
         rdy_q        <= 1'b0;
      end else begin
         sync_q       <= {sync_q[0], serialIn};
         baud_q       <= baudClock;
         state_q      <= state_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         shifter_q    <= shifter_d;
         rx_data_q    <= rx_data_d;
         data_valid_q <= data_valid_d;
         frame_err_q  <= frame_err_d;
         overrun_q    <= overrun_d;
         rdy_q        <= mem_valid & enable;
      end
   end

   assign mem_ready = enable & rdy_q;
   assign mem_rdata = enable ? {21'd0, overrun_q, frame_err_q, data_valid_q, rx_data_q} : 32'd0;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives 8N1 frames and bus accesses, comparing the status
// word against a byte/flag-level model of the receiver's observable behaviour.
module tb_uart_rx;

   localparam int BIT_T = 640;  // 16 baudClock periods of 40

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        enable    = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_ready;
   logic        mem_instr = 1'b0;
   logic [3:0]  mem_wstrb = 4'd0;
   logic [31:0] mem_wdata = 32'd0;
   logic [31:0] mem_addr  = 32'd0;
   logic [31:0] mem_rdata;
   logic        baudClock = 1'b0;
   logic        serialIn  = 1'b1;

   int checks = 0;
   int errors = 0;

   // Model of the visible receiver state
   logic [7:0] m_data;
   logic       m_valid, m_fe, m_ovr;

   logic [31:0] rd;
   logic        r1, r2;
   int          k;

   uart_rx #(.OVERSAMPLE(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_instr (mem_instr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .baudClock (baudClock),
      .serialIn  (serialIn)
   );

   always #5 clk = ~clk;
   initial begin
      #2;
      forever #20 baudClock = ~baudClock;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   function logic [31:0] exp_word();
      return {21'd0, m_ovr, m_fe, m_valid, m_data};
   endfunction

   task m_reset();
      m_data = 8'd0; m_valid = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
   endtask

   task m_rx(input logic [7:0] b);
      if (!m_valid) begin
         m_data  = b;
         m_valid = 1'b1;
      end else begin
         m_ovr = 1'b1;
      end
   endtask

   task send_frame(input logic [7:0] b, input int stop_low);
      @(posedge baudClock);
      #7;
      serialIn = 1'b0;
      #(BIT_T);
      for (int i = 0; i < 8; i++) begin
         serialIn = b[i];
         #(BIT_T);
      end
      if (stop_low == 0) begin
         serialIn = 1'b1;
         #(BIT_T);
      end else begin
         serialIn = 1'b0;
         #(BIT_T * stop_low);
      end
      $display("frame 0x%02h sent (stop low %0d bits)", b, stop_low);
   endtask

   task bus_read(output logic [31:0] data, output logic ready_first, output logic ready_second);
      @(negedge clk);
      enable = 1'b1; mem_valid = 1'b1; mem_wstrb = 4'b0000;
      #1 ready_first = mem_ready;
      @(negedge clk);
      ready_second = mem_ready;
      data = mem_rdata;
      @(negedge clk);
      mem_valid = 1'b0;
      $display("bus read -> 0x%08h", data);
   endtask

   task bus_write_clear();
      @(negedge clk);
      enable = 1'b1; mem_valid = 1'b1; mem_wstrb = 4'b0010;
      @(negedge clk);
      mem_valid = 1'b0; mem_wstrb = 4'b0000;
      $display("bus write wstrb=0010");
   endtask

   task test_reset();
      reset = 1'b1; enable = 1'b1; mem_valid = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (mem_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got 0x%08h expected 0x00000000", mem_rdata); end
      checks++;
      if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", mem_ready); end
      mem_valid = 1'b0;
      reset = 1'b0;
      m_reset();
      @(negedge clk);
      enable = 1'b0;
      #1;
      checks++;
      if (mem_rdata !== 32'd0) begin errors++; $display("FAIL disabled_rdata: got 0x%08h expected 0x00000000", mem_rdata); end
      enable = 1'b1;
      $display("reset released");
   endtask

   task test_basic();
      send_frame(8'hA5, 0);
      m_rx(8'hA5);
      @(negedge clk);
      checks++;
      if (mem_rdata[10:0] !== 11'h1A5) begin errors++; $display("FAIL a5_status: got 0x%03h expected 0x1a5", mem_rdata[10:0]); end
      bus_read(rd, r1, r2);
      checks++;
      if (r1 !== 1'b0) begin errors++; $display("FAIL ready_latency: got %b expected 0 in request cycle", r1); end
      checks++;
      if (r2 !== 1'b1) begin errors++; $display("FAIL ready_ack: got %b expected 1 one cycle later", r2); end
      checks++;
      if (rd !== exp_word()) begin errors++; $display("FAIL a5_read: got 0x%08h expected 0x%08h", rd, exp_word()); end
      m_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_rdata !== exp_word()) begin errors++; $display("FAIL a5_after_read: got 0x%08h expected 0x%08h", mem_rdata, exp_word()); end
   endtask

   task test_glitch();
      @(posedge baudClock);
      #7;
      serialIn = 1'b0;
      #120;
      serialIn = 1'b1;
      #(BIT_T * 11);
      @(negedge clk);
      $display("glitch of 3 baud periods sent");
      checks++;
      if (mem_rdata !== exp_word()) begin errors++; $display("FAIL glitch: got 0x%08h expected 0x%08h", mem_rdata, exp_word()); end
   endtask

   task test_frame_error();
      send_frame(8'h3C, 2);
      m_fe = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_rdata !== exp_word()) begin errors++; $display("FAIL frame_err_set: got 0x%08h expected 0x%08h", mem_rdata, exp_word()); end
      serialIn = 1'b1;
      bus_write_clear();
      m_fe = 1'b0;
      #(BIT_T * 10);
      @(negedge clk);
      checks++;
      if (mem_rdata !== exp_word()) begin errors++; $display("FAIL break_no_start: got 0x%08h expected 0x%08h", mem_rdata, exp_word()); end
      send_frame(8'hC3, 0);
      m_rx(8'hC3);
      @(negedge clk);
      checks++;
      if (mem_rdata !== exp_word()) begin errors++; $display("FAIL after_break_rx: got 0x%08h expected 0x%08h", mem_rdata, exp_word()); end
      bus_read(rd, r1, r2);
      m_valid = 1'b0;
   endtask

   task test_overrun();
      send_frame(8'h11, 0);
      m_rx(8'h11);
      send_frame(8'h22, 0);
      m_rx(8'h22);
      @(negedge clk);
      checks++;
      if (mem_rdata[10:0] !== 11'h511) begin errors++; $display("FAIL overrun: got 0x%03h expected 0x511", mem_rdata[10:0]); end
      bus_write_clear();
      m_ovr = 1'b0; m_fe = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_rdata !== exp_word()) begin errors++; $display("FAIL overrun_clear: got 0x%08h expected 0x%08h", mem_rdata, exp_word()); end
      bus_read(rd, r1, r2);
      checks++;
      if (rd !== exp_word()) begin errors++; $display("FAIL overrun_read: got 0x%08h expected 0x%08h", rd, exp_word()); end
      m_valid = 1'b0;
   endtask

   task test_same_cycle_read();
      // First frame measures delivery timing relative to the start-bit edge.
      fork
         send_frame(8'h44, 0);
         begin
            @(negedge serialIn);
            k = 0;
            while (mem_rdata[8] !== 1'b1 && k < 3000) begin
               @(negedge clk);
               k++;
            end
         end
      join
      checks++;
      if (k >= 3000) begin errors++; $display("FAIL delivery_timeout: got no dataValid within %0d cycles, required delivery", k); end
      m_rx(8'h44);
      // Second frame: the read's clearing edge is placed on the delivery edge.
      fork
         send_frame(8'h55, 0);
         begin
            @(negedge serialIn);
            repeat (k - 2) @(negedge clk);
            enable = 1'b1; mem_wstrb = 4'b0000; mem_valid = 1'b1;
            repeat (2) @(negedge clk);
            mem_valid = 1'b0;
         end
      join
      m_data = 8'h55; m_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_rdata[10:0] !== 11'h155) begin errors++; $display("FAIL same_cycle_read: got 0x%03h expected 0x155", mem_rdata[10:0]); end
      bus_read(rd, r1, r2);
      checks++;
      if (rd !== exp_word()) begin errors++; $display("FAIL same_cycle_followup: got 0x%08h expected 0x%08h", rd, exp_word()); end
      m_valid = 1'b0;
   endtask

   task test_reset_midframe();
      send_frame(8'h77, 0);
      m_rx(8'h77);
      fork
         send_frame(8'hFF, 0);
         begin
            @(negedge serialIn);
            #3520;
            reset = 1'b1;
            #50;
            reset = 1'b0;
         end
      join
      m_reset();
      @(negedge clk);
      checks++;
      if (mem_rdata !== exp_word()) begin errors++; $display("FAIL midframe_reset: got 0x%08h expected 0x%08h", mem_rdata, exp_word()); end
      send_frame(8'h0F, 0);
      m_rx(8'h0F);
      @(negedge clk);
      checks++;
      if (mem_rdata[10:0] !== 11'h10F) begin errors++; $display("FAIL after_reset_rx: got 0x%03h expected 0x10f", mem_rdata[10:0]); end
      bus_read(rd, r1, r2);
      m_valid = 1'b0;
   endtask

   task test_random();
      logic [7:0] b;
      int         act;
      for (int n = 0; n < 10; n++) begin
         b = 8'($urandom);
         send_frame(b, 0);
         m_rx(b);
         @(negedge clk);
         checks++;
         if (mem_rdata !== exp_word()) begin errors++; $display("FAIL random_rx[%0d]: got 0x%08h expected 0x%08h", n, mem_rdata, exp_word()); end
         enable = 1'b0; mem_valid = 1'b1;
         @(negedge clk);
         checks++;
         if (mem_rdata !== 32'd0 || mem_ready !== 1'b0) begin errors++; $display("FAIL random_disabled[%0d]: got rdata 0x%08h ready %b expected 0 and 0", n, mem_rdata, mem_ready); end
         mem_valid = 1'b0; enable = 1'b1;
         act = int'($urandom_range(0, 3));
         if (act <= 1) begin
            bus_read(rd, r1, r2);
            checks++;
            if (rd !== exp_word() || r2 !== 1'b1) begin errors++; $display("FAIL random_read[%0d]: got 0x%08h ready %b expected 0x%08h ready 1", n, rd, r2, exp_word()); end
            m_valid = 1'b0;
         end else if (act == 2) begin
            bus_write_clear();
            m_fe = 1'b0; m_ovr = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_rdata !== exp_word()) begin errors++; $display("FAIL random_clear[%0d]: got 0x%08h expected 0x%08h", n, mem_rdata, exp_word()); end
         end
      end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_basic();
      test_glitch();
      test_frame_error();
      test_overrun();
      test_same_cycle_read();
      test_reset_midframe();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
